// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 256Kx16 asynchronous SRAM initiator: FSM states,
// SRAM bus widths, default base address and the byte-address to word mapping.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int          SRAM_DATA_W       = 16;
    localparam int          SRAM_ADDR_W       = 18;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Word index wraps modulo 2^17; bits [1:0] of the byte address drop out.
    function automatic logic [SRAM_ADDR_W-2:0] word_of(input logic [31:0] address,
                                                      input logic [31:0] base);
        return (SRAM_ADDR_W-1)'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_wait_counter.sv
// sram_wait_counter: per-phase cycle counter, 0..ACCESS_CYCLES-1, with
// synchronous clear on phase entry and a 'last' flag on the final count.
module sram_wait_counter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int CNT_W         = $clog2(ACCESS_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    assign count = count_q;
    assign last  = (count_q == CNT_W'(ACCESS_CYCLES - 1));

    // Holds at the final count outside a phase so it never wraps on its own.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (!last) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage initiator performing one 32-bit load/store as two 16-bit SRAM
// accesses, low half first. Optional byte masking via `SRAM_BYTE_MASK_EN.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
`ifdef SRAM_BYTE_MASK_EN
    input  logic [3:0]             byte_en,
`endif
    output logic [31:0]            readData,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES);

    state_e                 state_q, state_d;
    logic                   is_wr_q;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [31:0]            wdata_q;
    logic [15:0]            rd_lo_q;
    logic [31:0]            readData_q;
    logic                   we_n_q, ce_n_q, oe_n_q, ub_n_q, lb_n_q;
    logic [SRAM_ADDR_W-1:0] sram_addr_q;
    logic                   dq_oe_q;
    logic [SRAM_DATA_W-1:0] dq_out_q;
`ifdef SRAM_BYTE_MASK_EN
    logic [3:0]             be_q;
    logic [3:0]             req_be;
`endif

    logic                   clr, last;
    logic [CNT_W-1:0]       count, cnt_d;
    logic                   start, req_wr, in_access_d, half_d;
    logic [SRAM_ADDR_W-2:0] req_word;
    logic [31:0]            req_wdata;

    sram_wait_counter #(
        .ACCESS_CYCLES(ACCESS_CYCLES),
        .CNT_W        (CNT_W)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .count(count),
        .last (last)
    );

    assign start = (state_q == ST_IDLE) && (rd_en || wr_en);

    // Outputs for the cycle after a start must use the live request, since
    // the latched copy only lands on the same edge.
    assign req_wr    = start ? wr_en : is_wr_q;
    assign req_word  = start ? word_of(address, BASE_ADDR) : word_q;
    assign req_wdata = start ? writeData : wdata_q;
`ifdef SRAM_BYTE_MASK_EN
    assign req_be    = start ? byte_en : be_q;
`endif

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin state_d = ST_LOW;  clr = 1'b1; end
            ST_LOW:  if (last)  begin state_d = ST_HIGH; clr = 1'b1; end
            ST_HIGH: if (last)  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        cnt_d       = clr ? '0 : count + 1'b1;
        in_access_d = (state_d == ST_LOW) || (state_d == ST_HIGH);
        half_d      = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            is_wr_q     <= 1'b0;
            we_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            sram_addr_q <= '0;
            dq_oe_q     <= 1'b0;
            readData_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                is_wr_q <= wr_en;
                word_q  <= word_of(address, BASE_ADDR);
                wdata_q <= writeData;
`ifdef SRAM_BYTE_MASK_EN
                be_q    <= byte_en;
`endif
            end
            ce_n_q  <= ~in_access_d;
            oe_n_q  <= ~(in_access_d && !req_wr);
            // WE rises for the last cycle of each phase so the address only moves while WE is high.
            we_n_q  <= ~(in_access_d && req_wr && (cnt_d != CNT_W'(ACCESS_CYCLES - 1)));
            dq_oe_q <= in_access_d && req_wr;
            dq_out_q <= half_d ? req_wdata[31:16] : req_wdata[15:0];
            if (in_access_d) begin
                sram_addr_q <= {req_word, half_d};
            end
`ifdef SRAM_BYTE_MASK_EN
            lb_n_q <= in_access_d ? ~(half_d ? req_be[2] : req_be[0]) : 1'b1;
            ub_n_q <= in_access_d ? ~(half_d ? req_be[3] : req_be[1]) : 1'b1;
`else
            lb_n_q <= ~in_access_d;
            ub_n_q <= ~in_access_d;
`endif
            if (state_q == ST_LOW && last && !is_wr_q) begin
                rd_lo_q <= SRAM_DQ;
            end
            if (state_q == ST_HIGH && last && !is_wr_q) begin
                readData_q <= {SRAM_DQ, rd_lo_q};
            end
        end
    end

    assign ready     = (state_q == ST_IDLE) ? ~(rd_en | wr_en) : (state_q == ST_DONE);
    assign readData  = readData_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: asynchronous SRAM model on the pins plus a
// word-level reference memory; directed steps followed by random accesses.
module tb_sram_controller;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst, rd_en, wr_en;
    logic [31:0] address, writeData;
    logic [3:0]  byte_en;
    wire  [31:0] readData;
    wire         ready;
    wire  [15:0] SRAM_DQ;
    wire  [17:0] SRAM_ADDR;
    wire         SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

    sram_controller dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .address  (address),
        .writeData(writeData),
`ifdef SRAM_BYTE_MASK_EN
        .byte_en  (byte_en),
`endif
        .readData (readData),
        .ready    (ready),
        .SRAM_DQ  (SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_UB_N(SRAM_UB_N),
        .SRAM_LB_N(SRAM_LB_N),
        .SRAM_WE_N(SRAM_WE_N),
        .SRAM_CE_N(SRAM_CE_N),
        .SRAM_OE_N(SRAM_OE_N)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model; probe_en lets the bench put a known value on DQ.
    logic [15:0] mem [0:262143];
    logic        probe_en = 1'b0;
    logic [15:0] probe_val = 16'h0000;
    assign SRAM_DQ = probe_en ? probe_val
                   : ((!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz);
    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
        end
    end

    logic [31:0] ref_mem [int];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'd1024) / 4;
        return off[16:0];
    endfunction

    function automatic logic [31:0] ref_read(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    // One access starting in the next IDLE cycle; checks pins every cycle and ends in DONE.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic scramble,
                          output logic [31:0] rdata);
        logic [16:0] wd;
        int          lowc, phase, c;
        logic        done, exp_lb, exp_ub;
        logic [17:0] exp_addr;
        wd = word_idx(a);
        @(posedge clk); #1;
        rd_en = r; wr_en = w; address = a; writeData = d;
        #1;
        check("start_ready", ready, 1'b0);
        check("start_ce", SRAM_CE_N, 1'b1);
        lowc = 1;
        done = 1'b0;
        for (int k = 1; k < 64 && !done; k++) begin
            @(posedge clk); #2;
            if (ready) begin
                done = 1'b1;
            end else begin
                lowc++;
                if (scramble) begin
                    address = $urandom; writeData = $urandom;
                end
                phase = (k - 1) / AC;
                c     = (k - 1) % AC;
                exp_addr = {wd, phase[0]};
                check("ce_active", SRAM_CE_N, 1'b0);
                check("addr", SRAM_ADDR, exp_addr);
`ifdef SRAM_BYTE_MASK_EN
                exp_lb = (phase == 0) ? ~byte_en[0] : ~byte_en[2];
                exp_ub = (phase == 0) ? ~byte_en[1] : ~byte_en[3];
`else
                exp_lb = 1'b0;
                exp_ub = 1'b0;
`endif
                check("lb_n", SRAM_LB_N, exp_lb);
                check("ub_n", SRAM_UB_N, exp_ub);
                if (w) begin
                    check("wr_we_n", SRAM_WE_N, (c == AC - 1));
                    check("wr_oe_n", SRAM_OE_N, 1'b1);
                    check("wr_dq", SRAM_DQ, (phase == 0) ? d[15:0] : d[31:16]);
                end else begin
                    check("rd_we_n", SRAM_WE_N, 1'b1);
                    check("rd_oe_n", SRAM_OE_N, 1'b0);
                end
            end
        end
        check("ready_low_cycles", lowc, 2 * AC + 1);
        check("done_ce", SRAM_CE_N, 1'b1);
        rdata = readData;
        rd_en = 1'b0; wr_en = 1'b0;
        if (w) ref_mem[int'(wd)] = d;
        else   check("read_data", rdata, ref_read(int'(wd)));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        r, w;
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        address = 32'h0; writeData = 32'h0; byte_en = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce", SRAM_CE_N, 1'b1);
        check("rst_we", SRAM_WE_N, 1'b1);
        check("rst_oe", SRAM_OE_N, 1'b1);
        check("rst_ub_lb", {SRAM_UB_N, SRAM_LB_N}, 2'b11);
        check("rst_addr", SRAM_ADDR, 18'h0);
        check("rst_rdata", readData, 32'h0);
        check("rst_ready", ready, 1'b1);
        rst = 1'b1;

        access(1'b0, 1'b1, 32'd1028, 32'h0000000B, 1'b0, rd);
        check("mem_w2", mem[2], 16'h000B);
        check("mem_w3", mem[3], 16'h0000);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, rd);
        check("load_1028", rd, 32'h0000000B);

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, rd);
        check("mem_w0", mem[0], 16'hBEEF);
        check("mem_w1", mem[1], 16'hDEAD);

        access(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b1, rd);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, rd);
        check("load_1032", rd, 32'h12345678);

        // Back-to-back loads: second request arrives in the IDLE right after DONE.
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, rd);
        check("b2b_first", rd, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, rd);
        check("b2b_second", rd, 32'h0000000B);

        // Address below the base wraps to the top word.
        access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 1'b0, rd);
        check("wrap_mem_hi", mem[18'h3FFFF], 16'hCAFE);
        access(1'b1, 1'b0, 32'd1023, 32'h0, 1'b0, rd);

        // Reset during the HIGH phase of a write.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1024 + 32'd400; writeData = 32'h5A3C0F0F;
        repeat (1 + AC) @(posedge clk);
        #1;
        check("pre_rst_high", {SRAM_CE_N, SRAM_ADDR[0]}, 2'b01);
        rst = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        check("abort_ce", SRAM_CE_N, 1'b1);
        check("abort_we", SRAM_WE_N, 1'b1);
        check("abort_oe", SRAM_OE_N, 1'b1);
        check("abort_ub_lb", {SRAM_UB_N, SRAM_LB_N}, 2'b11);
        check("abort_addr", SRAM_ADDR, 18'h0);
        check("abort_rdata", readData, 32'h0);
        check("abort_ready", ready, 1'b1);
        probe_en = 1'b1; probe_val = 16'hA5C3;
        #1;
        check("abort_dq_released", SRAM_DQ, 16'hA5C3);
        probe_en = 1'b0;
        rd_en = 1'b1;
        #1;
        check("rst_ready_req", ready, 1'b0);
        rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", {ready, SRAM_CE_N}, 2'b11);

`ifdef SRAM_BYTE_MASK_EN
        byte_en = 4'b0101;
        access(1'b0, 1'b1, 32'd1024 + 32'd800, 32'h11223344, 1'b0, rd);
        ref_mem.delete(200);
        byte_en = 4'hF;
`endif

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            access(r, w, 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)),
                   $urandom, 1'($urandom_range(0, 1)), rd);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                check("gap_ready", ready, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage initiator for the off-chip 256K×16 asynchronous SRAM. It accepts one 32-bit load or store per request from the pipeline's MEM stage and performs it as two 16-bit SRAM accesses, low half first. It holds `ready` low to stall the pipeline until the access completes. It drives the same SRAM pin set that the `SRAM` behavioural model and the board SRAM expose.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `ACCESS_CYCLES`, default 2: clock cycles per 16-bit phase. Must be ≥ 2.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `rd_en`  in  1: load request (MEM_R_EN).
- `wr_en`  in  1: store request (MEM_W_EN). Write wins if both `rd_en` and `wr_en` are high.
- `address`  in  32: byte address, word-aligned. Bits [1:0] are ignored.
- `writeData`  in  32: store data.
- `readData`  out  32: load result. Valid while `ready` is 1 after a read.
- `ready`  out  1: 0 means stall the pipeline.
- `SRAM_DQ`  inout  16: data bus. Tri-stated except during write phases.
- `SRAM_ADDR`  out  18: SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N`  out  1 each: byte masks.
- `SRAM_WE_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each: write enable, chip enable, output enable.

## Operation
- Address mapping: `off = address - BASE_ADDR`; `word = off[18:2]`. `SRAM_ADDR = {word[16:0], half}`, where half is 0 for the low phase and 1 for the high phase. Words wrap modulo 2^17 and there is no range check.
- FSM states and transitions:
  - IDLE: with no request, stays in IDLE and `ready`=1. With a request, moves to LOW. `ready` is combinationally `~(rd_en|wr_en)` in IDLE.
  - LOW: runs ACCESS_CYCLES cycles, then moves to HIGH.
  - HIGH: runs ACCESS_CYCLES cycles, then moves to DONE.
  - DONE: one cycle with `ready`=1, then moves to IDLE.
  - `ready`=0 in LOW and HIGH.
- Request latching: the request type, `address` and `writeData` are latched on the IDLE→LOW edge. Changes to the inputs mid-access are ignored.
- Phase cycle counter: 0..ACCESS_CYCLES-1. Cleared on every phase entry.
- Write phase:
  - `SRAM_DQ` is driven with `writeData[15:0]` in LOW and `writeData[31:16]` in HIGH.
  - `SRAM_WE_N`=0 for counter < ACCESS_CYCLES-1.
  - `SRAM_WE_N`=1 in the last cycle of each phase, so the address only changes while WE is high.
  - `SRAM_OE_N`=1 throughout.
- Read phase:
  - `SRAM_OE_N`=0 and `SRAM_WE_N`=1.
  - `SRAM_DQ` is sampled at the end of the last cycle of each phase into `rd_lo` or `rd_hi`.
  - `readData = {rd_hi, rd_lo}` is held until the next read completes.
- `SRAM_CE_N`=0 in LOW and HIGH, and 1 otherwise.
- `SRAM_UB_N`/`SRAM_LB_N` are 0 in LOW and HIGH, and 1 otherwise (see Configuration).
- Back-to-back requests: the pipeline advances during DONE. A request present in the following IDLE cycle starts a new access immediately. Minimum spacing between request starts is 2·ACCESS_CYCLES+2 cycles.

## Timing
- Latency: the request is seen in IDLE at cycle 0. `ready` is 0 for cycles 0..2·ACCESS_CYCLES and 1 in cycle 2·ACCESS_CYCLES+1 (DONE). With the defaults, `ready` is low for 5 cycles.
- All SRAM control outputs, `SRAM_ADDR` and the DQ drive enable are registered, so they are glitch-free. Each follows its state one cycle after the transition decision.
- Reset (`rst`=0 at an edge) has priority over everything, including an access in progress; the aborted access is dropped. Values after reset:
  - state = IDLE;
  - `SRAM_WE_N`=`SRAM_CE_N`=`SRAM_OE_N`=`SRAM_UB_N`=`SRAM_LB_N`=1;
  - `SRAM_ADDR`=0;
  - DQ tri-stated;
  - `readData`=0;
  - `ready` = `~(rd_en|wr_en)`.

## Configuration
- Macro `SRAM_BYTE_MASK_EN`.
- When defined:
  - the input `byte_en[3:0]` is added;
  - during an access, LOW drives `SRAM_LB_N = ~byte_en[0]` and `SRAM_UB_N = ~byte_en[1]`;
  - HIGH drives `SRAM_LB_N = ~byte_en[2]` and `SRAM_UB_N = ~byte_en[3]`;
  - `byte_en` is latched with the request.
- When undefined: the port is absent and both masks are 0 during any access.

## Structure
- Shared definitions go in `Defines.v`: FSM state encodings, `SRAM_DATA_W` (16), `SRAM_ADDR_W` (18), and the default `BASE_ADDR`.
- One natural sub-module, `sram_wait_counter`. It holds the phase counter and asserts `last` when count = ACCESS_CYCLES-1; it clears on `clr`.

## Test plan
- Store 0x0000000B to address 1028, then load 1028:
  - the write drives `SRAM_ADDR` 2 (data 0x000B) then 3 (data 0x0000);
  - the load returns `readData`=0x0000000B;
  - `ready` is low for exactly 5 cycles on each access.
- Store 0xDEADBEEF to address 1024:
  - LOW drives DQ=0xBEEF at `SRAM_ADDR`=0;
  - HIGH drives DQ=0xDEAD at `SRAM_ADDR`=1;
  - `SRAM_WE_N` is high in the last cycle of each phase.
- Assert `rd_en` and `wr_en` together on address 1032 with data 0x12345678: a write is performed, and a later read returns 0x12345678.
- Assert `rst`=0 during the HIGH phase of a write: on the next edge the FSM is in IDLE, all control outputs are 1, and DQ is Z.
- Issue back-to-back loads of 1024 and 1028: the second access starts the cycle after DONE, and both return their stored values.
- With `SRAM_BYTE_MASK_EN` defined and `byte_en`=4'b0101: LOW drives LB_N=0/UB_N=1 and HIGH drives LB_N=0/UB_N=1.
